axil_regbank: RTL

AXI4-Lite slave register bank: a directly addressable array of `P_NREGS` data-width registers that sits at the slave end of an `axi_if` link and terminates it. Writes honour byte strobes. Out-of-range accesses return SLVERR. Register contents are exported in parallel to the surrounding datapath, with a one-cycle per-register write strobe.

---
 rtl/axil_regbank_if.sv | 31 +++
 rtl/axil_regbank.sv | 95 +++++++++
 2 files changed

// File: rtl/axil_regbank_if.sv
// axi_if: AXI4-Lite link between one master and one slave.
interface axi_if #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [P_ASIZE-1:0]      awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [P_DBYTES*8-1:0]   wdata;
  logic [P_DBYTES-1:0]     wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [P_ASIZE-1:0]      araddr;
  logic                    rvalid;
  logic                    rready;
  logic [P_DBYTES*8-1:0]   rdata;
  logic [1:0]              rresp;
  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite register bank with byte strobes, SLVERR on out-of-range
// accesses, parallel register export and per-register write pulses.
module axil_regbank #(
  parameter int P_ASIZE  = 32,
  parameter int P_DBYTES = 4,
  parameter int P_NREGS  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  axi_if.slave                            s,
  output logic [P_NREGS*P_DBYTES*8-1:0]   regs_o,
  output logic [P_NREGS-1:0]              wr_pulse_o
);
  localparam int OFS = $clog2(P_DBYTES);
  localparam int DW  = P_DBYTES * 8;
  localparam int IW  = P_ASIZE - OFS;
  logic                          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IW-1:0]                 aw_idx_q, aw_idx_d, ar_idx;
  logic [DW-1:0]                 wdata_q, wdata_d, rdata_q, rdata_d, rd_word;
  logic [P_DBYTES-1:0]           wstrb_q, wstrb_d;
  logic                          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]                    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [P_NREGS-1:0][DW-1:0]    regs_q, regs_d;
  logic [P_NREGS-1:0]            pulse_q, pulse_d;
  logic                          aw_fire, w_fire, ar_fire, commit, aw_in, ar_in;
  always_comb begin
    aw_fire   = s.awvalid && !aw_held_q;
    w_fire    = s.wvalid && !w_held_q;
    ar_fire   = s.arvalid && !rvalid_q;
    commit    = aw_held_q && w_held_q && (!bvalid_q || s.bready);
    aw_in     = aw_idx_q < IW'(P_NREGS);
    ar_idx    = s.araddr[P_ASIZE-1:OFS];
    ar_in     = ar_idx < IW'(P_NREGS);
    aw_held_d = !commit && (aw_held_q || aw_fire);
    w_held_d  = !commit && (w_held_q || w_fire);
    aw_idx_d  = aw_fire ? s.awaddr[P_ASIZE-1:OFS] : aw_idx_q;
    wdata_d   = w_fire ? s.wdata : wdata_q;
    wstrb_d   = w_fire ? s.wstrb : wstrb_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    rd_word   = '0;
    for (int i = 0; i < P_NREGS; i++) begin
      if (commit && aw_in && aw_idx_q == IW'(i)) begin
        for (int b = 0; b < P_DBYTES; b++)
          if (wstrb_q[b]) regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
        pulse_d[i] = |wstrb_q;
      end
      if (ar_idx == IW'(i)) rd_word = regs_q[i];
    end
    bvalid_d = commit || (bvalid_q && !s.bready);
    bresp_d  = commit ? (aw_in ? 2'b00 : 2'b10) : bresp_q;
    rvalid_d = ar_fire || (rvalid_q && !s.rready);
    rdata_d  = ar_fire ? rd_word : rdata_q;
    rresp_d  = ar_fire ? (ar_in ? 2'b00 : 2'b10) : rresp_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      regs_q    <= '0;
      pulse_q   <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
    end
  end
  assign s.awready  = !aw_held_q;
  assign s.wready   = !w_held_q;
  assign s.bvalid   = bvalid_q;
  assign s.bresp    = bresp_q;
  assign s.arready  = !rvalid_q;
  assign s.rvalid   = rvalid_q;
  assign s.rdata    = rdata_q;
  assign s.rresp    = rresp_q;
  assign regs_o     = regs_q;
  assign wr_pulse_o = pulse_q;
endmodule
